fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 118 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time the FIFO write port
// for a whole packet, and counts completed packets per requester.
module fifo_wr_arbiter #(
  parameter int unsigned width = 8,
  parameter int unsigned nreq  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [nreq-1:0]       req_valid,
  input  logic [nreq*width-1:0] req_data,
  input  logic [nreq-1:0]       req_last,
  output logic [nreq-1:0]       req_ready,
  output logic                  fifo_wen,
  output logic [width-1:0]      fifo_wdata,
  input  logic                  fifo_full,
  output logic [nreq-1:0]       grant,
  output logic                  busy,
  output logic [nreq*8-1:0]     pkt_cnt
);

  localparam int unsigned IdxW = $clog2(nreq);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [nreq-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [7:0]        cnt_q [nreq];
  logic [7:0]        cnt_d [nreq];

  logic              win_found;
  logic [IdxW-1:0]   win_idx;
  logic              valid_g, last_g, xfer;
  logic [width-1:0]  sel_data;

  // First valid requester searching upward from the previous winner, wrapping.
  always_comb begin
    int unsigned idx;
    logic [IdxW-1:0] idx_n;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    idx_n     = '0;
    for (int unsigned k = 1; k <= nreq; k++) begin
      idx   = (32'(last_q) + k) % nreq;
      idx_n = IdxW'(idx);
      if (!win_found && req_valid[idx_n]) begin
        win_found = 1'b1;
        win_idx   = idx_n;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(nreq); i++) begin
      if (grant_q[i]) sel_data = req_data[i*width +: width];
    end
  end

  assign busy       = (state_q == StBusy);
  assign valid_g    = |(req_valid & grant_q);
  assign last_g     = |(req_last & grant_q);
  assign xfer       = busy && !rst && valid_g && !fifo_full;
  assign fifo_wen   = xfer;
  assign req_ready  = (busy && !rst && !fifo_full) ? grant_q : '0;
  assign fifo_wdata = (busy && !rst) ? sel_data : '0;
  assign grant      = grant_q;

  always_comb begin
    pkt_cnt = '0;
    for (int i = 0; i < int'(nreq); i++) pkt_cnt[i*8 +: 8] = cnt_q[i];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d          = StBusy;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
        end
      end
      StBusy: begin
        if (xfer && last_g) begin
          state_d = StIdle;
          grant_d = '0;
          for (int i = 0; i < int'(nreq); i++) begin
            if (grant_q[i]) begin
              last_d   = IdxW'(i);
              cnt_d[i] = cnt_q[i] + 8'd1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdxW'(nreq - 1);
      for (int i = 0; i < int'(nreq); i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-cycle vector table plus hand-written corner sequences;
// every FIFO write is matched against a queue of expected data.
module tb_fifo_wr_arbiter;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_ready;
  logic          fifo_wen;
  logic [W-1:0]  fifo_wdata;
  logic          fifo_full = 1'b0;
  logic [N-1:0]  grant;
  logic          busy;
  logic [N*8-1:0] pkt_cnt;

  int total = 0;
  int bad = 0;
  int misgrant = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.width(W), .nreq(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .grant      (grant),
    .busy       (busy),
    .pkt_cnt    (pkt_cnt)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        f;
    logic        chk;
    logic [3:0]  g;
    logic        b;
    logic        w;
    logic [3:0]  rdy;
    logic [31:0] cnt;
    logic [7:0]  wd;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one cycle just after the rising edge, queue any expected write, sample at negedge.
  task automatic cyc(input logic r, input logic [3:0] v, input logic [3:0] l,
                     input logic [31:0] d, input logic f, input logic push,
                     input logic [7:0] pv);
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    req_last  = l;
    req_data  = d;
    fifo_full = f;
    if (push) exp_q.push_back(pv);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(1'b1, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, 8'h00);
  endtask

  always @(negedge clk) begin
    if (fifo_wen) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got wdata=%h, want no write", fifo_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fifo_wdata !== mon_exp) begin
          bad++;
          $display("FAIL write_data: got %h want %h", fifo_wdata, mon_exp);
        end
      end
    end
  end

  initial begin
    //          rst   v      l      d             f     chk   g      b     w     rdy    cnt            wd
    tbl[0]  = '{1'b1, 4'h0, 4'h0, 32'h00000000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 32'h00000000, 8'h00};
    tbl[1]  = '{1'b1, 4'h1, 4'h0, 32'h00000011, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 32'h00000000, 8'h00};
    tbl[2]  = '{1'b0, 4'h1, 4'h0, 32'h00000011, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 32'h00000000, 8'h00};
    tbl[3]  = '{1'b0, 4'h1, 4'h0, 32'h00000011, 1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 4'h1, 32'h00000000, 8'h11};
    tbl[4]  = '{1'b0, 4'h1, 4'h0, 32'h00000022, 1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 4'h1, 32'h00000000, 8'h22};
    tbl[5]  = '{1'b0, 4'h1, 4'h1, 32'h00000033, 1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 4'h1, 32'h00000000, 8'h33};
    tbl[6]  = '{1'b0, 4'h0, 4'h0, 32'h00000000, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 32'h00000001, 8'h00};
    tbl[7]  = '{1'b0, 4'h4, 4'h0, 32'h00A10000, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 32'h00000001, 8'h00};
    tbl[8]  = '{1'b0, 4'h4, 4'h0, 32'h00A10000, 1'b0, 1'b1, 4'h4, 1'b1, 1'b1, 4'h4, 32'h00000001, 8'hA1};
    tbl[9]  = '{1'b0, 4'h4, 4'h0, 32'h00A20000, 1'b1, 1'b1, 4'h4, 1'b1, 1'b0, 4'h0, 32'h00000001, 8'h00};
    tbl[10] = '{1'b0, 4'h5, 4'h0, 32'h00A200FF, 1'b1, 1'b1, 4'h4, 1'b1, 1'b0, 4'h0, 32'h00000001, 8'h00};
    tbl[11] = '{1'b0, 4'h5, 4'h0, 32'h00A200FF, 1'b1, 1'b1, 4'h4, 1'b1, 1'b0, 4'h0, 32'h00000001, 8'h00};
    tbl[12] = '{1'b0, 4'h5, 4'h0, 32'h00A200FF, 1'b0, 1'b1, 4'h4, 1'b1, 1'b1, 4'h4, 32'h00000001, 8'hA2};
    tbl[13] = '{1'b0, 4'h5, 4'h4, 32'h00A300FF, 1'b0, 1'b1, 4'h4, 1'b1, 1'b1, 4'h4, 32'h00000001, 8'hA3};
    tbl[14] = '{1'b0, 4'h0, 4'h0, 32'h00000000, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 32'h00010001, 8'h00};

    // Single 3-beat packet, then a requester-2 packet stalled by fifo_full.
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].rst, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].f, tbl[i].w, tbl[i].wd);
      if (tbl[i].chk) begin
        check($sformatf("v%0d_grant", i), 32'(grant), 32'(tbl[i].g));
        check($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].b));
        check($sformatf("v%0d_wen", i), 32'(fifo_wen), 32'(tbl[i].w));
        check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
        check($sformatf("v%0d_cnt", i), pkt_cnt, tbl[i].cnt);
        if (!tbl[i].b) check($sformatf("v%0d_wdata0", i), 32'(fifo_wdata), 32'h0);
      end
    end

    // All four requesters continuously valid with one-beat packets.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      logic [3:0] eg;
      logic [7:0] pv;
      eg = (k % 2 == 1) ? 4'(1 << (((k - 1) / 2) % 4)) : 4'h0;
      pv = 8'h40 + 8'(((k - 1) / 2) % 4);
      cyc(1'b0, 4'hF, 4'hF, 32'h43424140, 1'b0, (k % 2 == 1), pv);
      check($sformatf("rr_grant_k%0d", k), 32'(grant), 32'(eg));
    end

    // Requester 3 raises valid while requester 1 holds the grant.
    do_reset();
    cyc(1'b0, 4'b0010, 4'b0000, 32'h0000B100, 1'b0, 1'b0, 8'h00);
    check("lock_arb_idle", 32'(grant), 32'h0);
    cyc(1'b0, 4'b0010, 4'b0000, 32'h0000B100, 1'b0, 1'b1, 8'hB1);
    check("lock_g1_b1", 32'(grant), 32'h2);
    cyc(1'b0, 4'b1010, 4'b1000, 32'hD300B200, 1'b0, 1'b1, 8'hB2);
    check("lock_g1_b2", 32'(grant), 32'h2);
    check("lock_ready_b2", 32'(req_ready), 32'h2);
    cyc(1'b0, 4'b1010, 4'b1010, 32'hD300B300, 1'b0, 1'b1, 8'hB3);
    check("lock_g1_b3", 32'(grant), 32'h2);
    cyc(1'b0, 4'b1000, 4'b1000, 32'hD3000000, 1'b0, 1'b0, 8'h00);
    check("lock_idle_gap", 32'(grant), 32'h0);
    check("lock_idle_busy", 32'(busy), 32'h0);
    cyc(1'b0, 4'b1000, 4'b1000, 32'hD3000000, 1'b0, 1'b1, 8'hD3);
    check("lock_g3", 32'(grant), 32'h8);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0, 8'h00);
    check("lock_cnt", pkt_cnt, 32'h01000100);

    // Reset during the second beat of a requester-0 packet.
    do_reset();
    cyc(1'b0, 4'b0001, 4'b0000, 32'h000000C1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 4'b0001, 4'b0000, 32'h000000C1, 1'b0, 1'b1, 8'hC1);
    check("abort_g0", 32'(grant), 32'h1);
    cyc(1'b1, 4'b0001, 4'b0000, 32'h000000C2, 1'b0, 1'b0, 8'h00);
    check("abort_wen_in_rst", 32'(fifo_wen), 32'h0);
    check("abort_ready_in_rst", 32'(req_ready), 32'h0);
    check("abort_wdata_in_rst", 32'(fifo_wdata), 32'h0);
    cyc(1'b0, 4'b0011, 4'b0011, 32'h0000E1C4, 1'b0, 1'b0, 8'h00);
    check("abort_grant0", 32'(grant), 32'h0);
    check("abort_busy0", 32'(busy), 32'h0);
    check("abort_cnt0", pkt_cnt, 32'h0);
    cyc(1'b0, 4'b0011, 4'b0011, 32'h0000E1C4, 1'b0, 1'b1, 8'hC4);
    check("abort_rearb_g0", 32'(grant), 32'h1);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0, 8'h00);
    check("abort_cnt1", pkt_cnt, 32'h1);

    // 256 one-beat packets from requester 1 wrap its counter.
    do_reset();
    for (int k = 0; k < 512; k++) begin
      cyc(1'b0, 4'b0010, 4'b0010, 32'h00005A00, 1'b0, (k % 2 == 1), 8'h5A);
      if (grant !== ((k % 2 == 1) ? 4'b0010 : 4'b0000)) misgrant++;
      if (k == 510) check("wrap_cnt255", 32'(pkt_cnt[15:8]), 32'd255);
    end
    check("wrap_always_req1", 32'(misgrant), 32'h0);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0, 8'h00);
    check("wrap_cnt0", pkt_cnt, 32'h0);
    check("wrap_grant_idle", 32'(grant), 32'h0);

    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0, 8'h00);
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
